// File: rtl/serial_add_sched.sv
// Round-robin scheduler for two requesters sharing one bit-serial full-adder slice.
// Operands are added LSB first, one bit per clock, and the result is held until it is consumed.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             id_r, last_grant;
    logic             grant0, grant1, take;
    logic             s_bit, c_bit;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign take       = req0_ready | req1_ready;
    assign busy       = (state != IDLE);

    assign {c_bit, s_bit} = full_add(a_sh[0], b_sh[0], carry);
    // New sum bit enters at the MSB so that after WIDTH shifts bit i sits at position i.
    assign sum_nxt = (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = RUN;
            RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (take) begin
                        a_sh       <= grant0 ? req0_a : req1_a;
                        b_sh       <= grant0 ? req0_b : req1_b;
                        id_r       <= grant1;
                        last_grant <= grant1;
                        carry      <= 1'b0;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_bit;
                    sum_sh <= sum_nxt;
                    if (cnt == LAST_BIT) begin
                        res_sum   <= sum_nxt;
                        res_cout  <= c_bit;
                        res_id    <= id_r;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
